// File: rtl/fpu_pipeline_stage.sv
`default_nettype none
// ============================================================================
// fpu_pipeline_stage : valid/ready FPU inter-stage register. Defining
// FPU_STAGE_SKID_EN adds a skid entry so in_ready comes straight from a flop.
// Revision : 1.0
// ============================================================================
module fpu_pipeline_stage #(
  parameter int                DATA_W     = 64,
  parameter int                CTRL_W     = 32,
  parameter logic [CTRL_W-1:0] CTRL_RESET = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic [CTRL_W-1:0] m_ctrl;
  logic              accept;

  assign out_valid = m_valid;
  assign out_data  = m_data;
  assign out_ctrl  = m_ctrl;

`ifdef FPU_STAGE_SKID_EN
  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic [CTRL_W-1:0] s_ctrl;
  logic              m_drain;
  logic              load_m_from_s;
  logic              load_m_from_in;
  logic              load_s;

  assign in_ready       = !s_valid;
  assign accept         = in_valid && !s_valid;
  assign m_drain        = !m_valid || out_ready;
  // A held skid beat always has priority over a new input (FIFO order).
  assign load_m_from_s  = !flush && m_drain && s_valid;
  assign load_m_from_in = !flush && m_drain && !s_valid && accept;
  assign load_s         = !flush && !m_drain && accept;
  assign occupancy      = {1'b0, m_valid} + {1'b0, s_valid};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (m_drain) begin
      m_valid <= s_valid || accept;
      s_valid <= 1'b0;
    end else if (accept) begin
      s_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ctrl <= CTRL_RESET;
      s_ctrl <= CTRL_RESET;
    end else begin
      if (load_m_from_s) begin
        m_ctrl <= s_ctrl;
      end else if (load_m_from_in) begin
        m_ctrl <= in_ctrl;
      end
      if (load_s) begin
        s_ctrl <= in_ctrl;
      end
    end
  end

  // Datapath payload is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (load_m_from_s) begin
      m_data <= s_data;
    end else if (load_m_from_in) begin
      m_data <= in_data;
    end
    if (load_s) begin
      s_data <= in_data;
    end
  end
`else
  logic load_m;

  assign in_ready  = !m_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign load_m    = !flush && accept;
  assign occupancy = {1'b0, m_valid};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
    end else if (flush) begin
      m_valid <= 1'b0;
    end else if (in_ready) begin
      m_valid <= accept;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ctrl <= CTRL_RESET;
    end else if (load_m) begin
      m_ctrl <= in_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (load_m) begin
      m_data <= in_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_pipeline_stage.sv
`default_nettype none
// tb_fpu_pipeline_stage : directed stimulus with a scoreboard queue filled on
// accept and drained by an independent output monitor.
module tb_fpu_pipeline_stage;
  localparam int                DATA_W   = 64;
  localparam int                CTRL_W   = 32;
  localparam logic [CTRL_W-1:0] CTRL_RST = 32'hA5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic [1:0]        occupancy;

  always #5 clk = ~clk;

  fpu_pipeline_stage #(
    .DATA_W    (DATA_W),
    .CTRL_W    (CTRL_W),
    .CTRL_RESET(CTRL_RST)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_ctrl  (in_ctrl),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ctrl (out_ctrl),
    .occupancy(occupancy)
  );

  typedef struct {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
    int                due;
  } beat_t;

  beat_t sb[$];
  beat_t mon_e;
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;
  logic  lat_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard fill: a beat accepted on the coming edge is expected downstream.
  always @(negedge clk) begin
    if (reset_n && !flush && in_valid && in_ready)
      sb.push_back('{d: in_data, c: in_ctrl, due: (lat_chk ? cyc + 1 : -1)});
  end

  // Monitor: every beat consumed downstream must match the queue head.
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", out_data, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        mon_e = sb.pop_front();
        chk("out_data", out_data, mon_e.d);
        chk("out_ctrl", {32'h0, out_ctrl}, {32'h0, mon_e.c});
        if (mon_e.due >= 0) chk("latency", 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic fin();
    @(posedge clk);
    #1;
  endtask

  // Backpressure tables, per cycle: out_ready driven, then expected values
  // sampled mid-cycle.
  int bp_or [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  int bp_ov [11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
`ifdef FPU_STAGE_SKID_EN
  int bp_ir [11] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 1, 1};
  int bp_occ[11] = '{0, 1, 1, 2, 2, 2, 1, 1, 1, 1, 0};
  localparam int FL_OCC = 2;
`else
  int bp_ir [11] = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  int bp_occ[11] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  localparam int FL_OCC = 1;
`endif

  initial begin
    int   nxt;
    logic acc;

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_ctrl", {32'h0, out_ctrl}, 64'hA5);
    reset_n = 1'b1;
    fin();

    // Streaming 1..8 with out_ready high throughout
    lat_chk   = 1'b1;
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i);
      in_ctrl  = 32'h100 + 32'(i);
      fin();
    end
    in_valid = 1'b0;
    repeat (3) fin();
    lat_chk = 1'b0;
    chk("stream_drained_valid", 64'(out_valid), 64'd0);
    chk("stream_drained_sb", 64'(sb.size()), 64'd0);

    // Backpressure: 1..6 offered, out_ready low for three cycles
    nxt = 1;
    for (int c = 0; c < 11; c++) begin
      in_valid  = (nxt <= 6);
      in_data   = 64'(nxt);
      in_ctrl   = 32'h200 + 32'(nxt);
      out_ready = (bp_or[c] != 0);
      @(negedge clk);
      chk($sformatf("bp_in_ready_c%0d", c), 64'(in_ready), 64'(bp_ir[c]));
      chk($sformatf("bp_occ_c%0d", c), 64'(occupancy), 64'(bp_occ[c]));
      chk($sformatf("bp_out_valid_c%0d", c), 64'(out_valid), 64'(bp_ov[c]));
      acc = in_valid && in_ready;
      fin();
      if (acc) nxt++;
    end
    in_valid = 1'b0;
    chk("bp_sb_empty", 64'(sb.size()), 64'd0);

    // Flush while full, with a beat offered on the flush edge
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h11;
    in_ctrl   = 32'h311;
    fin();
    in_data   = 64'h22;
    in_ctrl   = 32'h322;
    fin();
    in_data   = 64'h33;
    in_ctrl   = 32'h333;
    flush     = 1'b1;
    @(negedge clk);
    chk("fl_occ_before", 64'(occupancy), 64'(FL_OCC));
    fin();
    sb.delete();
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_occ_after", 64'(occupancy), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    // Flush again while empty: the accepted input must be discarded
    in_data = 64'h44;
    in_ctrl = 32'h344;
    fin();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl2_out_valid", 64'(out_valid), 64'd0);
    chk("fl2_occ", 64'(occupancy), 64'd0);
    out_ready = 1'b1;
    repeat (2) fin();

    // Asynchronous reset while holding beats
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 64'h55;
    in_ctrl   = 32'h455;
    fin();
    in_data   = 64'h66;
    in_ctrl   = 32'h466;
    fin();
    in_valid  = 1'b0;
    @(negedge clk);
    chk("ar_held_valid", 64'(out_valid), 64'd1);
    chk("ar_held_occ", 64'(occupancy), 64'(FL_OCC));
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_occ", 64'(occupancy), 64'd0);
    chk("ar_out_ctrl", {32'h0, out_ctrl}, 64'hA5);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    sb.delete();
    #1;
    reset_n = 1'b1;
    fin();
    chk("ar_post_valid", 64'(out_valid), 64'd0);

    // Recovery after reset: one beat through
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 64'h77;
    in_ctrl   = 32'h577;
    fin();
    in_valid = 1'b0;
    @(negedge clk);
    chk("rec_out_valid", 64'(out_valid), 64'd1);
    repeat (2) fin();
    chk("final_sb_empty", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
